// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
//
// Purpose:
//   Shares the register file's single write port between two writeback
//   requesters: the ALU result path (alu_*) and the memory load path (mem_*).
//   Each requester uses a valid/ready handshake. When both ask in the same
//   cycle, a round-robin pointer picks the winner. The accepted request is
//   registered and presented to the register file one cycle later. Saturating
//   counters record accepted transfers and conflict cycles for perf readout.
//
// Parameters:
//   ADDR_W  register address width
//   DATA_W  write data width
//   CNT_W   width of each statistics counter
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   wb_enable           global write permit; 0 blocks every grant
//   alu_valid/ready     ALU writeback handshake (ready is combinational)
//   alu_addr/data       ALU destination register and result
//   mem_valid/ready     load writeback handshake (ready is combinational)
//   mem_addr/data       load destination register and data
//   rf_wEna             registered register-file write enable
//   rf_write_addr       registered register-file write address
//   rf_WD               registered register-file write data
//   alu_cnt, mem_cnt    accepted transfers per requester, saturating
//   conflict_cnt        cycles with both requesters valid while enabled
// ---------------------------------------------------------------------------
module rf_write_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_enable,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              rf_wEna,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_WD,
  output logic [CNT_W-1:0]  alu_cnt,
  output logic [CNT_W-1:0]  mem_cnt,
  output logic [CNT_W-1:0]  conflict_cnt
);

  // Which requester wins the next conflict.
  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_MEM = 1'b1
  } rr_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  rr_t               rr_ptr;
  logic              conflict;
  logic              alu_xfer;
  logic              mem_xfer;
  logic              any_xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Grant logic. A requester is ready only while it is valid and
  // writeback is enabled; on a conflict the round-robin pointer decides, so
  // at most one ready is ever high.
  always_comb begin
    conflict  = wb_enable & alu_valid & mem_valid;
    alu_ready = wb_enable & alu_valid & (~mem_valid | (rr_ptr == PRI_ALU));
    mem_ready = wb_enable & mem_valid & (~alu_valid | (rr_ptr == PRI_MEM));
    alu_xfer  = alu_ready;
    mem_xfer  = mem_ready;
    any_xfer  = alu_xfer | mem_xfer;
    sel_addr  = mem_xfer ? mem_addr : alu_addr;
    sel_data  = mem_xfer ? mem_data : alu_data;
  end

  // Round-robin pointer. It moves only on a granted conflict, and then
  // points at the loser so the loser wins the next conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= PRI_ALU;
    end else if (conflict) begin
      rr_ptr <= alu_xfer ? PRI_MEM : PRI_ALU;
    end
  end

  // Write stage. Writes to r0 are accepted but never enabled so r0 stays
  // zero; address and data hold their last value whenever nothing is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wEna       <= 1'b0;
      rf_write_addr <= '0;
      rf_WD         <= '0;
    end else if (any_xfer && (sel_addr != '0)) begin
      rf_wEna       <= 1'b1;
      rf_write_addr <= sel_addr;
      rf_WD         <= sel_data;
    end else begin
      rf_wEna       <= 1'b0;
    end
  end

  // Statistics counters. Each one sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_cnt      <= '0;
      mem_cnt      <= '0;
      conflict_cnt <= '0;
    end else begin
      if (alu_xfer && (alu_cnt != CNT_MAX)) begin
        alu_cnt <= alu_cnt + CNT_ONE;
      end
      if (mem_xfer && (mem_cnt != CNT_MAX)) begin
        mem_cnt <= mem_cnt + CNT_ONE;
      end
      if (conflict && (conflict_cnt != CNT_MAX)) begin
        conflict_cnt <= conflict_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_write_arbiter
//
// Purpose:
//   Self-checking bench for rf_write_arbiter. Runs a table of hand-computed
//   cycles, then random requesters checked against a behavioural model,
//   then a counter saturation sequence on a narrow-counter instance.
// ---------------------------------------------------------------------------
module tb_rf_write_arbiter;

  localparam int CMAX = 65535;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_enable = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_addr = '0;
  logic [31:0] alu_data = '0;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_addr = '0;
  logic [31:0] mem_data = '0;

  logic        alu_ready, mem_ready, rf_wEna;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_WD;
  logic [15:0] alu_cnt, mem_cnt, conflict_cnt;

  logic        s_alu_ready, s_mem_ready, s_wEna;
  logic [4:0]  s_addr;
  logic [31:0] s_wd;
  logic [1:0]  s_alu_cnt, s_mem_cnt, s_conflict_cnt;

  int total = 0;
  int bad = 0;

  // Behavioural model state
  bit          m_pref_mem;
  bit          m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  int          m_ac, m_mc, m_cc;
  // Model results for the current cycle and its pending next state
  bit          e_ar, e_mr;
  bit          n_pref_mem, n_we;
  logic [4:0]  n_wa;
  logic [31:0] n_wd;
  int          n_ac, n_mc, n_cc;

  rf_write_arbiter #(.ADDR_W(5), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .wb_enable(wb_enable),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .rf_wEna(rf_wEna), .rf_write_addr(rf_write_addr), .rf_WD(rf_WD),
    .alu_cnt(alu_cnt), .mem_cnt(mem_cnt), .conflict_cnt(conflict_cnt)
  );

  rf_write_arbiter #(.ADDR_W(5), .DATA_W(32), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .wb_enable(wb_enable),
    .alu_valid(alu_valid), .alu_ready(s_alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(s_mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .rf_wEna(s_wEna), .rf_write_addr(s_addr), .rf_WD(s_wd),
    .alu_cnt(s_alu_cnt), .mem_cnt(s_mem_cnt), .conflict_cnt(s_conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wb, av;
    logic [4:0]  aa;
    logic [31:0] ad;
    bit          mv;
    logic [4:0]  ma;
    logic [31:0] md;
    bit          ar, mr, we;
    logic [4:0]  wa;
    logic [31:0] wd;
    int          ac, mc, cc;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(bit wb, bit av, logic [4:0] aa, logic [31:0] ad,
                              bit mv, logic [4:0] ma, logic [31:0] md,
                              bit ar, bit mr, bit we, logic [4:0] wa, logic [31:0] wd,
                              int ac, int mc, int cc);
    vec_t v;
    v.wb = wb; v.av = av; v.aa = aa; v.ad = ad; v.mv = mv; v.ma = ma; v.md = md;
    v.ar = ar; v.mr = mr; v.we = we; v.wa = wa; v.wd = wd;
    v.ac = ac; v.mc = mc; v.cc = cc;
    return v;
  endfunction

  function automatic int satInc(int v, int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  // One comparison; prints a FAIL line on mismatch
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic modelReset();
    m_pref_mem = 0; m_we = 0; m_wa = '0; m_wd = '0;
    m_ac = 0; m_mc = 0; m_cc = 0;
  endtask

  // Drive one cycle's inputs at the falling edge and work out what the
  // model expects for the grants and for the state after the next edge.
  task automatic applyStimulus(input bit wb, input bit av, input logic [4:0] aa, input logic [31:0] ad,
                               input bit mv, input logic [4:0] ma, input logic [31:0] md);
    bit both;
    @(negedge clk);
    wb_enable = wb; alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    #1;
    both = wb && av && mv;
    e_ar = wb && av && (!mv || !m_pref_mem);
    e_mr = wb && mv && (!av || m_pref_mem);
    n_pref_mem = both ? e_ar : m_pref_mem;
    n_ac = e_ar ? satInc(m_ac, CMAX) : m_ac;
    n_mc = e_mr ? satInc(m_mc, CMAX) : m_mc;
    n_cc = both ? satInc(m_cc, CMAX) : m_cc;
    n_we = 0; n_wa = m_wa; n_wd = m_wd;
    if (e_ar && aa != 0) begin n_we = 1; n_wa = aa; n_wd = ad; end
    if (e_mr && ma != 0) begin n_we = 1; n_wa = ma; n_wd = md; end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
    m_pref_mem = n_pref_mem; m_we = n_we; m_wa = n_wa; m_wd = n_wd;
    m_ac = n_ac; m_mc = n_mc; m_cc = n_cc;
  endtask

  // Assert reset between clock edges and expect every output to clear at once
  task automatic doReset();
    @(negedge clk);
    #2;
    wb_enable = 0; alu_valid = 0; mem_valid = 0;
    rst = 1;
    #1;
    checkOutput("rst_wEna", 64'(rf_wEna), 64'(0));
    checkOutput("rst_addr", 64'(rf_write_addr), 64'(0));
    checkOutput("rst_wd", 64'(rf_WD), 64'(0));
    checkOutput("rst_alu_cnt", 64'(alu_cnt), 64'(0));
    checkOutput("rst_mem_cnt", 64'(mem_cnt), 64'(0));
    checkOutput("rst_conflict_cnt", 64'(conflict_cnt), 64'(0));
    checkOutput("rst_small_alu_cnt", 64'(s_alu_cnt), 64'(0));
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    bit          ra_v, rm_v;
    logic [4:0]  ra_a, rm_a;
    logic [31:0] ra_d, rm_d;

    // Hand-computed cycles starting from reset (ALU has priority first)
    vecs[0]  = mk(1,1,3,32'h11,       0,0,0,          1,0,1,3,32'h11,        1,0,0);
    vecs[1]  = mk(1,1,1,32'hA,        1,2,32'hB,      1,0,1,1,32'hA,         2,0,1);
    vecs[2]  = mk(1,1,1,32'hA,        1,2,32'hB,      0,1,1,2,32'hB,         2,1,2);
    vecs[3]  = mk(1,1,1,32'hA,        1,2,32'hB,      1,0,1,1,32'hA,         3,1,3);
    vecs[4]  = mk(1,1,1,32'hA,        1,2,32'hB,      0,1,1,2,32'hB,         3,2,4);
    vecs[5]  = mk(1,0,0,0,            1,0,32'hFFFFFFFF, 0,1,0,2,32'hB,       3,3,4);
    vecs[6]  = mk(0,1,1,32'hA,        1,2,32'hB,      0,0,0,2,32'hB,         3,3,4);
    vecs[7]  = mk(0,1,1,32'hA,        1,2,32'hB,      0,0,0,2,32'hB,         3,3,4);
    vecs[8]  = mk(0,1,1,32'hA,        1,2,32'hB,      0,0,0,2,32'hB,         3,3,4);
    vecs[9]  = mk(1,1,1,32'hA,        1,2,32'hB,      1,0,1,1,32'hA,         4,3,5);
    vecs[10] = mk(1,1,5,32'h1,        0,0,0,          1,0,1,5,32'h1,         5,3,5);
    vecs[11] = mk(1,0,0,0,            1,5,32'h2,      0,1,1,5,32'h2,         5,4,5);
    vecs[12] = mk(1,0,0,0,            0,0,0,          0,0,0,5,32'h2,         5,4,5);
    vecs[13] = mk(1,1,7,32'h7,        1,8,32'h8,      0,1,1,8,32'h8,         5,5,6);

    $display("[TB] start");
    doReset();

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].wb, vecs[i].av, vecs[i].aa, vecs[i].ad,
                    vecs[i].mv, vecs[i].ma, vecs[i].md);
      checkOutput($sformatf("vec%0d_alu_ready", i), 64'(alu_ready), 64'(vecs[i].ar));
      checkOutput($sformatf("vec%0d_mem_ready", i), 64'(mem_ready), 64'(vecs[i].mr));
      stepClock();
      checkOutput($sformatf("vec%0d_wEna", i), 64'(rf_wEna), 64'(vecs[i].we));
      checkOutput($sformatf("vec%0d_addr", i), 64'(rf_write_addr), 64'(vecs[i].wa));
      checkOutput($sformatf("vec%0d_wd", i), 64'(rf_WD), 64'(vecs[i].wd));
      checkOutput($sformatf("vec%0d_alu_cnt", i), 64'(alu_cnt), 64'(vecs[i].ac));
      checkOutput($sformatf("vec%0d_mem_cnt", i), 64'(mem_cnt), 64'(vecs[i].mc));
      checkOutput($sformatf("vec%0d_conflict_cnt", i), 64'(conflict_cnt), 64'(vecs[i].cc));
    end

    // A write is pending on the port here; reset must cancel it immediately
    doReset();

    // Random requesters that hold their request until it is accepted
    ra_v = 0; rm_v = 0; ra_a = '0; rm_a = '0; ra_d = '0; rm_d = '0;
    for (int c = 0; c < 400; c++) begin
      if (!ra_v && $urandom_range(1, 0) == 1) begin
        ra_v = 1;
        ra_a = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 0));
        ra_d = $urandom;
      end
      if (!rm_v && $urandom_range(1, 0) == 1) begin
        rm_v = 1;
        rm_a = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 0));
        rm_d = $urandom;
      end
      applyStimulus($urandom_range(4, 0) != 0, ra_v, ra_a, ra_d, rm_v, rm_a, rm_d);
      checkOutput("rnd_alu_ready", 64'(alu_ready), 64'(e_ar));
      checkOutput("rnd_mem_ready", 64'(mem_ready), 64'(e_mr));
      stepClock();
      if (e_ar) ra_v = 0;
      if (e_mr) rm_v = 0;
      checkOutput("rnd_wEna", 64'(rf_wEna), 64'(m_we));
      checkOutput("rnd_addr", 64'(rf_write_addr), 64'(m_wa));
      checkOutput("rnd_wd", 64'(rf_WD), 64'(m_wd));
      checkOutput("rnd_alu_cnt", 64'(alu_cnt), 64'(m_ac));
      checkOutput("rnd_mem_cnt", 64'(mem_cnt), 64'(m_mc));
      checkOutput("rnd_conflict_cnt", 64'(conflict_cnt), 64'(m_cc));
    end

    // Narrow counters must stick at 3
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 5'd3, 32'(i + 1), 0, 5'd0, 32'd0);
      stepClock();
      checkOutput($sformatf("sat%0d_small_alu_cnt", i), 64'(s_alu_cnt), 64'((i + 1 > 3) ? 3 : i + 1));
      checkOutput($sformatf("sat%0d_alu_cnt", i), 64'(alu_cnt), 64'(m_ac));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
